ddr_wr_data_fifo: RTL and testbench

//   Single-clock synchronous FIFO that buffers 512-bit write data for the DDR3 DMA

---
 rtl/ddr_wr_data_fifo.sv | 72 +++++++
 tb/tb_ddr_wr_data_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_data_fifo.sv
// Single-clock write-data FIFO for the DDR3 DMA write path, with registered dout and prog_full backpressure.
// Optional macro DDR_WR_FIFO_COUNT_EN adds a data_count occupancy output.
module ddr_wr_data_fifo #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 9,
  parameter int PROG_FULL_THRESH = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  prog_full
`ifdef DDR_WR_FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   data_count
`endif
);

  localparam int                  DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] THRESH_CNT = (ADDR_WIDTH + 1)'(PROG_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc;
  logic                  rd_acc;

  // Accept decisions use the flags as they stood before the edge.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately left out of reset so it maps to RAM;
  // stale contents are unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= din;
  end

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign prog_full = (count >= THRESH_CNT);

`ifdef DDR_WR_FIFO_COUNT_EN
  assign data_count = count;
`endif

endmodule

// File: tb/tb_ddr_wr_data_fifo.sv
// Randomized self-checking bench for ddr_wr_data_fifo against a queue-based occupancy/data model.
module tb_ddr_wr_data_fifo;

  localparam int DW     = 512;
  localparam int AW     = 9;
  localparam int DEPTH  = 1 << AW;
  localparam int THRESH = 480;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] din = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic          prog_full;
`ifdef DDR_WR_FIFO_COUNT_EN
  logic [AW:0]   data_count;
`endif

  ddr_wr_data_fifo #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .PROG_FULL_THRESH(THRESH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .din       (din),
    .rd_en     (rd_en),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .prog_full (prog_full)
`ifdef DDR_WR_FIFO_COUNT_EN
    ,
    .data_count(data_count)
`endif
  );

  always #5 clk = ~clk;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout = '0;
  logic [DW-1:0] seq = '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".empty"},     DW'(empty),     DW'(q.size() == 0));
    check({tag, ".full"},      DW'(full),      DW'(q.size() == DEPTH));
    check({tag, ".prog_full"}, DW'(prog_full), DW'(q.size() >= THRESH));
    check({tag, ".dout"},      dout,           exp_dout);
`ifdef DDR_WR_FIFO_COUNT_EN
    check({tag, ".count"},     DW'(data_count), DW'(q.size()));
`endif
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // One clock: drive, let the edge happen, advance the model, then sample 1 ns later.
  task automatic cycle(input string tag, input logic w, input logic [DW-1:0] d, input logic r);
    bit wa, ra;
    wr_en = w; din = d; rd_en = r;
    @(posedge clk);
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    if (ra) exp_dout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_state(tag);
  endtask

  task automatic push_seq(input string tag);
    seq = seq + 1'b1;
    cycle(tag, 1'b1, seq, 1'b0);
  endtask

  initial begin
    // Reset state.
    #2;
    check_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ordering: push 1..16, pop 16.
    for (int i = 0; i < 16; i++) push_seq("ord_push");
    for (int i = 0; i < 16; i++) cycle("ord_pop", 1'b0, '0, 1'b1);
    check("ord_last", dout, DW'(16));

    // Underflow: reads on empty hold dout; wr+rd on empty only writes.
    for (int i = 0; i < 3; i++) cycle("uf_rd", 1'b0, '0, 1'b1);
    cycle("uf_wrrd", 1'b1, rand_word(), 1'b1);
    check("uf_hold", dout, DW'(16));
    cycle("uf_drain", 1'b0, '0, 1'b1);

    // Thresholds: 479, 480, 512, then a dropped 513th push.
    for (int i = 0; i < THRESH - 1; i++) push_seq("thr_fill");
    check("pf_479", DW'(prog_full), '0);
    push_seq("thr_480");
    check("pf_480", DW'(prog_full), DW'(1));
    while (q.size() < DEPTH) push_seq("thr_to_full");
    check("full_512", DW'(full), DW'(1));
    cycle("ovf_drop", 1'b1, rand_word(), 1'b0);

    // wr+rd when full: only the read happens.
    cycle("full_wrrd", 1'b1, rand_word(), 1'b1);
    check("full_wrrd_full", DW'(full), '0);

    // Drain to 256, then 1000 cycles of steady wr+rd across pointer wrap.
    while (q.size() > 256) cycle("drain", 1'b0, '0, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      seq = seq + 1'b1;
      cycle("steady", 1'b1, seq, 1'b1);
    end
    check("steady_pf", DW'(prog_full), '0);

    // Random traffic with shifting bias so both flags get exercised.
    for (int i = 0; i < 3000; i++) begin
      int unsigned wbias;
      wbias = (i / 500) % 2 ? 30 : 70;
      cycle("rand", $urandom_range(99) < wbias, rand_word(), $urandom_range(99) < 50);
    end

    // Asynchronous reset mid-operation, seen without a clock edge.
    while (q.size() < 40) push_seq("pre_rst");
    cycle("pre_rst_rd", 1'b0, '0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    exp_dout = '0;
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_state("post_rst");

    // Old data must be gone; new data flows in order.
    for (int i = 0; i < 5; i++) cycle("rst_push", 1'b1, rand_word(), 1'b0);
    for (int i = 0; i < 6; i++) cycle("rst_pop", 1'b0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
